// File: rtl/rv32_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rv32_mul_sequencer
//  Purpose  : Iterative radix-2 shift-add multiplier for RV32M MUL, MULH,
//             MULHSU and MULHU. It multiplies the operand magnitudes over
//             32 iterations (or fewer with early-out), applies a sign
//             fix-up, and returns a one-cycle result strobe.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Build option:
//    RV32_MUL_EARLY_OUT_EN - when defined, CALC exits as soon as the
//                            remaining multiplier bits are all zero. Results
//                            are identical; only the latency changes.
// ----------------------------------------------------------------------------
//  Ports:
//    clk         in   1   core clock, rising edge
//    rst         in   1   synchronous active-high reset
//    req_valid   in   1   request present
//    req_ready   out  1   unit can accept a request this cycle
//    req_op      in   2   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//    req_a       in  32   rs1 operand
//    req_b       in  32   rs2 operand
//    kill        in   1   pipeline flush, abandons the in-flight operation
//    busy        out  1   operation in flight (CALC or SIGN)
//    resp_valid  out  1   one-cycle result strobe
//    resp_data   out 32   result, held until the next resp_valid
// ============================================================================
module rv32_mul_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        kill,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_data
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_SIGN   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    localparam logic [4:0] C_LAST_CNT = 5'd31;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]  state_q,     state_d;
    logic [63:0] mcand_q,     mcand_d;
    logic [31:0] mplier_q,    mplier_d;
    logic [63:0] prod_q,      prod_d;
    logic [4:0]  cnt_q,       cnt_d;
    logic        neg_q,       neg_d;
    logic [1:0]  op_q,        op_d;
    logic [31:0] resp_data_q, resp_data_d;

    // ------------------------------------------------------------------------
    // Operand decode on the request side
    // ------------------------------------------------------------------------
    logic        w_accept;
    logic        w_a_signed;
    logic        w_b_signed;
    logic        w_sign_a;
    logic        w_sign_b;
    logic [32:0] w_a_ext;
    logic [32:0] w_a_mag;
    logic [32:0] w_b_ext;
    logic [32:0] w_b_mag;

    assign w_accept   = req_valid && req_ready;

    // rs1 is unsigned only for MULHU; rs2 is signed only for MUL/MULH.
    assign w_a_signed = (req_op != OP_MULHU);
    assign w_b_signed = (req_op == OP_MUL) || (req_op == OP_MULH);

    assign w_sign_a   = w_a_signed && req_a[31];
    assign w_sign_b   = w_b_signed && req_b[31];

    // Magnitudes are formed on a 33-bit sign-extended value so that
    // 0x80000000 negates to +2^31 instead of wrapping back to itself.
    assign w_a_ext    = {w_sign_a, req_a};
    assign w_b_ext    = {w_sign_b, req_b};
    assign w_a_mag    = w_sign_a ? (~w_a_ext + 33'd1) : w_a_ext;
    assign w_b_mag    = w_sign_b ? (~w_b_ext + 33'd1) : w_b_ext;

    // ------------------------------------------------------------------------
    // Iteration and fix-up arithmetic
    // ------------------------------------------------------------------------
    logic [63:0] w_prod_add;
    logic [63:0] w_prod_fix;
    logic        w_calc_last;

    assign w_prod_add = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
    assign w_prod_fix = neg_q ? (~prod_q + 64'd1) : prod_q;

`ifdef RV32_MUL_EARLY_OUT_EN
    // Once the bits left after this shift are all zero, further iterations
    // would only add zero, so the product is already complete.
    assign w_calc_last = (cnt_q == C_LAST_CNT) || (mplier_q[31:1] == 31'd0);
`else
    assign w_calc_last = (cnt_q == C_LAST_CNT);
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        op_d        = op_q;
        resp_data_d = resp_data_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_CALC: begin
                prod_d   = w_prod_add;
                mcand_d  = {mcand_q[62:0], 1'b0};
                mplier_d = {1'b0, mplier_q[31:1]};
                cnt_d    = cnt_q + 5'd1;
                if (w_calc_last) begin
                    state_d = ST_SIGN;
                end
            end
            ST_SIGN: begin
                prod_d  = w_prod_fix;
                state_d = ST_DONE;
                // A killed operation must leave the previous result visible.
                if (!kill) begin
                    resp_data_d = (op_q == OP_MUL) ? w_prod_fix[31:0]
                                                   : w_prod_fix[63:32];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept is only possible from IDLE or DONE (req_ready), so this
        // load never collides with an iteration in progress.
        if (w_accept) begin
            mcand_d  = {31'd0, w_a_mag};
            mplier_d = w_b_mag[31:0];
            neg_d    = w_sign_a ^ w_sign_b;
            prod_d   = 64'd0;
            cnt_d    = 5'd0;
            op_d     = req_op;
            state_d  = ST_CALC;
        end

        if (kill) begin
            state_d = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mcand_q     <= 64'd0;
            mplier_q    <= 32'd0;
            prod_q      <= 64'd0;
            cnt_q       <= 5'd0;
            neg_q       <= 1'b0;
            op_q        <= OP_MUL;
            resp_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            op_q        <= op_d;
            resp_data_q <= resp_data_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req_ready  = !kill && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign busy       = (state_q == ST_CALC) || (state_q == ST_SIGN);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_data  = resp_data_q;

    // MULHSU is decoded through w_a_signed/w_b_signed; the named constant
    // documents the encoding table.
    logic w_unused_ok;
    assign w_unused_ok = (OP_MULHSU == 2'b10);

endmodule
`default_nettype wire

// File: tb/tb_rv32_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv32_mul_sequencer
//  Purpose  : Self-checking bench for rv32_mul_sequencer. Expected results
//             and latencies are pushed to a scoreboard when a request is
//             accepted and popped when resp_valid is observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_mul_sequencer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        kill;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;

    rv32_mul_sequencer u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .kill       (kill),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_data  (resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] data;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] last_data = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference product: full 64-bit multiply of the extended operands.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] sa, sb, p;
        sa = (op != 2'd3) ? {{32{a[31]}}, a} : {32'd0, a};
        sb = (op <= 2'd1) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = sa * sb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
`ifdef RV32_MUL_EARLY_OUT_EN
        logic [31:0] m;
        int k;
        m = ((op <= 2'd1) && b[31]) ? (32'd0 - b) : b;
        k = 0;
        for (int i = 0; i < 32; i++) if (m[i]) k = i;
        return (m <= 32'd1) ? 2 : k + 2;
`else
        return 33;
`endif
    endfunction

    // Monitor / scoreboard, sampling mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    check("spurious_resp", {63'd0, resp_valid}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("resp_data", {32'd0, resp_data}, {32'd0, e.data});
                    check("latency", 64'(cyc - e.acc), 64'(e.lat));
                    last_data = e.data;
                end
            end
            if (kill) begin
                sb_q.delete();
            end else if (req_valid && req_ready) begin
                e.data = model(req_op, req_a, req_b);
                e.acc  = cyc + 1;
                e.lat  = exp_lat(req_op, req_b);
                sb_q.push_back(e);
            end
        end
    end

    // Drives a request (called shortly after a rising edge) and returns
    // just after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 50);
        if (n >= 50) check("issue_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #2;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) check("resp_timeout", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        @(negedge clk);
        check("busy_inflight", {63'd0, busy}, 64'd1);
        drain();
    endtask

    logic [1:0]  d_op [6] = '{2'd0, 2'd1, 2'd3, 2'd2, 2'd3, 2'd0};
    logic [31:0] d_a  [6] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h12345678, 32'd5};
    logic [31:0] d_b  [6] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd0, 32'h00010000};

    initial begin
        int n;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        kill      = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_ready",      {63'd0, req_ready},  64'd1);
        check("rst_busy",       {63'd0, busy},       64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_data",  {32'd0, resp_data},  64'd0);
        @(posedge clk);
        #2;

        // Directed operations, including signed-overflow and zero cases.
        for (int i = 0; i < 6; i++) run_op(d_op[i], d_a[i], d_b[i]);

        // Random operations, with some small multipliers mixed in.
        for (int i = 0; i < 8; i++) begin
            run_op(2'($urandom_range(0, 3)), $urandom(),
                   (i < 2) ? 32'($urandom_range(0, 1)) : $urandom());
        end

        // Back-to-back: new request driven during the DONE cycle.
        issue(2'd1, 32'hDEADBEEF, 32'h01234567);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!resp_valid && n < 60);
        if (n >= 60) check("b2b_done", {63'd0, resp_valid}, 64'd1);
        req_op    = 2'd0;
        req_a     = 32'hFFFF0001;
        req_b     = 32'h00000003;
        req_valid = 1'b1;
        @(posedge clk);
        #2 req_valid = 1'b0;
        @(negedge clk);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        drain();
        repeat (3) @(negedge clk);
        check("resp_hold", {32'd0, resp_data}, {32'd0, last_data});
        @(posedge clk);
        #2;

        // Kill in CALC cycle 10, with a competing request.
        issue(2'd3, 32'hCAFEF00D, 32'h87654321);
        repeat (9) @(posedge clk);
        #2;
        kill      = 1'b1;
        req_op    = 2'd0;
        req_a     = 32'd9;
        req_b     = 32'd9;
        req_valid = 1'b1;
        @(negedge clk);
        check("kill_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk);
        #2;
        kill      = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("kill_busy",       {63'd0, busy},       64'd0);
        check("kill_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("kill_idle_ready", {63'd0, req_ready},  64'd1);
        repeat (40) @(negedge clk);
        check("kill_resp_data", {32'd0, resp_data}, {32'd0, last_data});

        // Unit still operational after the kill.
        @(posedge clk);
        #2;
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
